ring_freq_meter: RTL and testbench



---
 rtl/ring_freq_meter.sv | 211 +++++++++++++++++++++
 tb/tb_ring_freq_meter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_freq_meter.sv
// ============================================================================
// ring_freq_meter
// ----------------------------------------------------------------------------
// Multi-channel frequency meter for the on-die ring-oscillator bank. One ring
// is selected per measurement. Its rising edges are counted over a window of
// CLK cycles, and the result is presented with a valid/ack handshake.
//
// A measurement passes through four states:
//   IDLE   -> SETTLE (4 cycles)   -> GATE (N cycles) -> DONE (until ack)
// The total cost is N+6 cycles per measurement when the consumer acks at once.
//
// Configuration macro:
//   RING_PRESCALE_EN  When defined, each ring drives its own 2-bit ripple
//                     prescaler, and the mux picks the prescaler MSB. The
//                     count then becomes ring edges / 4.
//                     When undefined, raw rings are muxed directly.
//
// Ports:
//   CLK      system clock
//   RST      asynchronous active-low reset
//   I_RING   raw ring-oscillator outputs (asynchronous to CLK)
//   I_SEL    channel to measure, latched on the start cycle
//   I_GATE   window length in CLK cycles, latched on start (0 = 2^pGATE_W)
//   I_START  start request, honoured only in IDLE
//   I_ACK    consumer acknowledge, honoured only in DONE
//   O_COUNT  edges counted in the last window, stable while O_VALID=1
//   O_VALID  result available
//   O_OVF    counter saturated during the last window
//   O_BUSY   measurement in progress (SETTLE or GATE)
// ============================================================================
`timescale 1ns/1ps

module ring_freq_meter #(
    parameter int pCHANNELS = 6,
    parameter int pSEL_W    = 6,
    parameter int pGATE_W   = 12,
    parameter int pCNT_W    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [pCHANNELS-1:0] I_RING,
    input  logic [pSEL_W-1:0]    I_SEL,
    input  logic [pGATE_W-1:0]   I_GATE,
    input  logic                 I_START,
    input  logic                 I_ACK,
    output logic [pCNT_W-1:0]    O_COUNT,
    output logic                 O_VALID,
    output logic                 O_OVF,
    output logic                 O_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_DONE
    } state_t;

    state_t              state;
    logic [pSEL_W-1:0]   sel_q;
    logic [pGATE_W-1:0]  gate_q;
    logic [pGATE_W-1:0]  gate_elapsed;
    logic [pGATE_W-1:0]  gate_last;
    logic [1:0]          settle_cnt;
    logic [pCHANNELS-1:0] ring_src;
    logic                ring_mux;
    logic                sync_1;
    logic                sync_2;
    logic                sync_prev;
    logic                rise;
    logic [pCNT_W-1:0]   edge_cnt;
    logic [pCNT_W-1:0]   cnt_next;
    logic                ovf_q;
    logic                ovf_next;

`ifdef RING_PRESCALE_EN
    // Each ring clocks its own 2-bit ripple counter. The MSB toggles at a
    // quarter of the ring rate, so rings up to nearly 2*f_CLK stay measurable.
    // These are the only flops outside the CLK domain.
    genvar g;
    generate
        for (g = 0; g < pCHANNELS; g++) begin : g_prescale
            logic [1:0] pre_cnt;

            always_ff @(posedge I_RING[g] or negedge RST) begin
                if (!RST) begin
                    pre_cnt <= 2'd0;
                end else begin
                    pre_cnt <= pre_cnt + 2'd1;
                end
            end

            assign ring_src[g] = pre_cnt[1];
        end
    endgenerate
`else
    assign ring_src = I_RING;
`endif

    // Combinational channel mux. A select value with no matching channel
    // leaves the output at constant 0. An out-of-range measurement therefore
    // completes normally with a zero count.
    always_comb begin
        ring_mux = 1'b0;
        for (int i = 0; i < pCHANNELS; i++) begin
            if (sel_q == pSEL_W'(i)) begin
                ring_mux = ring_src[i];
            end
        end
    end

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    // This chain always runs. The 4-cycle SETTLE state flushes the stale
    // channel out of it before counting starts.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= ring_mux;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_prev;

    // Saturating increment. An edge that arrives with the counter already at
    // all-ones is lost, so that edge raises the overflow flag.
    always_comb begin
        cnt_next = edge_cnt;
        ovf_next = ovf_q;
        if (rise) begin
            if (&edge_cnt) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + pCNT_W'(1);
            end
        end
    end

    // The elapsed-cycle counter compares against gate_q-1 with wrap-around.
    // A latched gate of 0 therefore runs the full 2^pGATE_W cycles without an
    // extra counter bit.
    assign gate_last = gate_q - pGATE_W'(1);

    // Measurement FSM. All outputs are registered here. O_BUSY rises with the
    // start edge and falls on the same edge that raises O_VALID, so the two
    // outputs are never high together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= ST_IDLE;
            sel_q        <= '0;
            gate_q       <= '0;
            gate_elapsed <= '0;
            settle_cnt   <= 2'd0;
            edge_cnt     <= '0;
            ovf_q        <= 1'b0;
            O_COUNT      <= '0;
            O_VALID      <= 1'b0;
            O_OVF        <= 1'b0;
            O_BUSY       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_START) begin
                        sel_q      <= I_SEL;
                        gate_q     <= I_GATE;
                        settle_cnt <= 2'd0;
                        edge_cnt   <= '0;
                        ovf_q      <= 1'b0;
                        O_BUSY     <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == 2'd3) begin
                        gate_elapsed <= '0;
                        state        <= ST_GATE;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                ST_GATE: begin
                    edge_cnt <= cnt_next;
                    ovf_q    <= ovf_next;
                    if (gate_elapsed == gate_last) begin
                        O_COUNT <= cnt_next;
                        O_OVF   <= ovf_next;
                        O_VALID <= 1'b1;
                        O_BUSY  <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        gate_elapsed <= gate_elapsed + pGATE_W'(1);
                    end
                end
                ST_DONE: begin
                    if (I_ACK) begin
                        O_VALID <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_freq_meter.sv
// ============================================================================
// tb_ring_freq_meter
// ----------------------------------------------------------------------------
// Self-checking bench for ring_freq_meter. The bench uses three instances:
//   dut      default parameters (main functional tests)
//   dut_ovf  pCNT_W=4, for saturation
//   dut_g4   pGATE_W=4, for the gate-length-zero case
// Expected results are pushed to a scoreboard queue when a measurement is
// started, then popped and compared when O_VALID appears.
// ============================================================================
`timescale 1ns/1ps

module tb_ring_freq_meter;

    typedef struct {
        string name;
        int    lo;
        int    hi;
        logic  ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   basic_lo;
    int   basic_hi;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        r0, r1, r2, r3, r5;
    logic [5:0]  ring;
    logic [5:0]  sel;

    logic [11:0] gate_m;
    logic        start_m, ack_m;
    logic [15:0] count_m;
    logic        valid_m, ovf_m, busy_m;

    logic        start_o, ack_o;
    logic [3:0]  count_o;
    logic        valid_o, ovf_o, busy_o;

    logic [3:0]  gate_g;
    logic        start_g, ack_g;
    logic [15:0] count_g;
    logic        valid_g, ovf_g, busy_g;

    // 10 ns system clock; rising edges at 5, 15, 25 ...
    always #5 CLK = ~CLK;

    // Ring sources: ch0 40 ns, ch1 200 ns, ch2 80 ns, ch3 60 ns, ch4 idle,
    // ch5 400 ns. Ring edges fall on 2 mod 10 ns and never on a CLK edge.
    assign ring = {r5, 1'b0, r3, r2, r1, r0};
    initial begin r0 = 1'b0; #2; forever #20  r0 = ~r0; end
    initial begin r1 = 1'b0; #2; forever #100 r1 = ~r1; end
    initial begin r2 = 1'b0; #2; forever #40  r2 = ~r2; end
    initial begin r3 = 1'b0; #2; forever #30  r3 = ~r3; end
    initial begin r5 = 1'b0; #2; forever #200 r5 = ~r5; end

    ring_freq_meter dut (
        .CLK(CLK), .RST(rst_n), .I_RING(ring), .I_SEL(sel), .I_GATE(gate_m),
        .I_START(start_m), .I_ACK(ack_m), .O_COUNT(count_m), .O_VALID(valid_m),
        .O_OVF(ovf_m), .O_BUSY(busy_m)
    );

    ring_freq_meter #(.pCNT_W(4)) dut_ovf (
        .CLK(CLK), .RST(rst_n), .I_RING(ring), .I_SEL(sel), .I_GATE(gate_m),
        .I_START(start_o), .I_ACK(ack_o), .O_COUNT(count_o), .O_VALID(valid_o),
        .O_OVF(ovf_o), .O_BUSY(busy_o)
    );

    ring_freq_meter #(.pGATE_W(4)) dut_g4 (
        .CLK(CLK), .RST(rst_n), .I_RING(ring), .I_SEL(sel), .I_GATE(gate_g),
        .I_START(start_g), .I_ACK(ack_g), .O_COUNT(count_g), .O_VALID(valid_g),
        .O_OVF(ovf_g), .O_BUSY(busy_g)
    );

    // Global time limit so a stuck DUT can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Starts a measurement on the main DUT and waits for O_VALID. It returns
    // the number of edges from the start edge up to the first valid sample,
    // and the number of post-edge samples with O_BUSY high. After the start
    // edge, sel is moved to channel 1 so that a missing latch shows up.
    task automatic applyStimulus(input logic [5:0] s, input logic [11:0] g,
                                 output int lat, output int busy_n);
        @(negedge CLK);
        sel = s; gate_m = g; start_m = 1'b1;
        @(posedge CLK); #1;
        busy_n = busy_m ? 1 : 0;
        lat = 0;
        @(negedge CLK);
        start_m = 1'b0;
        sel = 6'd1;
        while (lat < 5000) begin
            @(posedge CLK); #1;
            lat++;
            if (valid_m) break;
            if (busy_m) busy_n++;
        end
    endtask

    task automatic ackMain();
        @(negedge CLK);
        ack_m = 1'b1;
        @(posedge CLK); #1;
        ack_m = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (count_m !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count_m); end
        checks++; if (valid_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_m); end
        checks++; if (ovf_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf_m); end
        checks++; if (busy_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_m); end
        @(negedge CLK);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_count();
        int lat, bn;
        exp_t e;
`ifdef RING_PRESCALE_EN
        basic_lo = 24; basic_hi = 26;
`else
        basic_lo = 99; basic_hi = 101;
`endif
        sb.push_back('{"basic", basic_lo, basic_hi, 1'b0});
        applyStimulus(6'd2, 12'd800, lat, bn);
        checks++; if (lat !== 804) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 804", lat); end
        checks++; if (bn !== 804) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 804", bn); end
        e = sb.pop_front();
        checks++; if (int'(count_m) < e.lo || int'(count_m) > e.hi) begin errors++; $display("[TB] FAIL %s_count: got %0d expected %0d..%0d", e.name, count_m, e.lo, e.hi); end
        checks++; if (ovf_m !== e.ovf) begin errors++; $display("[TB] FAIL %s_ovf: got %b expected %b", e.name, ovf_m, e.ovf); end
    endtask

    // Result is held for 50 cycles with a start pulse in between. Then it is
    // acknowledged and a new start is issued in the very next cycle.
    task automatic test_handshake();
        int lat, bn;
        exp_t e;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            start_m = (i == 10);
            @(posedge CLK); #1;
            checks++;
            if (valid_m !== 1'b1 || busy_m !== 1'b0 || int'(count_m) < basic_lo || int'(count_m) > basic_hi) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b busy=%b count=%0d expected valid=1 busy=0 count %0d..%0d", i, valid_m, busy_m, count_m, basic_lo, basic_hi);
            end
        end
        start_m = 1'b0;
        ackMain();
        checks++; if (valid_m !== 1'b0) begin errors++; $display("[TB] FAIL ack_valid_fall: got %b expected 0", valid_m); end
`ifdef RING_PRESCALE_EN
        sb.push_back('{"short", 0, 2, 1'b0});
`else
        sb.push_back('{"short", 1, 4, 1'b0});
`endif
        applyStimulus(6'd2, 12'd20, lat, bn);
        checks++; if (lat !== 24) begin errors++; $display("[TB] FAIL restart_latency: got %0d expected 24", lat); end
        e = sb.pop_front();
        checks++; if (int'(count_m) < e.lo || int'(count_m) > e.hi) begin errors++; $display("[TB] FAIL %s_count: got %0d expected %0d..%0d", e.name, count_m, e.lo, e.hi); end
        ackMain();
    endtask

    task automatic test_overflow();
        int lat;
        exp_t e;
        sb.push_back('{"overflow", 15, 15, 1'b1});
        @(negedge CLK);
        sel = 6'd0; gate_m = 12'd400; start_o = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        start_o = 1'b0;
        lat = 0;
        while (lat < 2000 && valid_o !== 1'b1) begin
            @(posedge CLK); #1;
            lat++;
        end
        e = sb.pop_front();
        checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid: got %b expected 1", valid_o); end
        checks++; if (int'(count_o) < e.lo || int'(count_o) > e.hi) begin errors++; $display("[TB] FAIL %s_count: got %0d expected %0d", e.name, count_o, e.lo); end
        checks++; if (ovf_o !== e.ovf) begin errors++; $display("[TB] FAIL %s_flag: got %b expected %b", e.name, ovf_o, e.ovf); end
        @(negedge CLK); ack_o = 1'b1;
        @(posedge CLK); #1; ack_o = 1'b0;
    endtask

    task automatic test_gate_zero();
        int lat, bn;
        exp_t e;
`ifdef RING_PRESCALE_EN
        sb.push_back('{"gate0", 0, 2, 1'b0});
`else
        sb.push_back('{"gate0", 1, 3, 1'b0});
`endif
        @(negedge CLK);
        sel = 6'd2; gate_g = 4'd0; start_g = 1'b1;
        @(posedge CLK); #1;
        bn = busy_g ? 1 : 0;
        lat = 0;
        @(negedge CLK);
        start_g = 1'b0;
        while (lat < 200) begin
            @(posedge CLK); #1;
            lat++;
            if (valid_g) break;
            if (busy_g) bn++;
        end
        checks++; if (bn !== 20) begin errors++; $display("[TB] FAIL gate0_busy_cycles: got %0d expected 20", bn); end
        checks++; if (lat !== 20) begin errors++; $display("[TB] FAIL gate0_latency: got %0d expected 20", lat); end
        e = sb.pop_front();
        checks++; if (int'(count_g) < e.lo || int'(count_g) > e.hi || ovf_g !== e.ovf) begin errors++; $display("[TB] FAIL %s_count: got %0d ovf=%b expected %0d..%0d ovf=%b", e.name, count_g, ovf_g, e.lo, e.hi, e.ovf); end
        @(negedge CLK); ack_g = 1'b1;
        @(posedge CLK); #1; ack_g = 1'b0;
    endtask

    task automatic test_invalid_sel();
        int lat, bn;
        exp_t e;
        sb.push_back('{"badsel", 0, 0, 1'b0});
        applyStimulus(6'd7, 12'd50, lat, bn);
        checks++; if (lat !== 54) begin errors++; $display("[TB] FAIL badsel_latency: got %0d expected 54", lat); end
        e = sb.pop_front();
        checks++; if (int'(count_m) < e.lo || int'(count_m) > e.hi) begin errors++; $display("[TB] FAIL %s_count: got %0d expected %0d", e.name, count_m, e.lo); end
        checks++; if (ovf_m !== e.ovf) begin errors++; $display("[TB] FAIL %s_ovf: got %b expected %b", e.name, ovf_m, e.ovf); end
        ackMain();
    endtask

    // Back-to-back measurements: a fast channel, then a slow one started in
    // the cycle right after the ack.
    task automatic test_channel_switch();
        int lat, bn;
        exp_t e;
`ifdef RING_PRESCALE_EN
        sb.push_back('{"ch0", 24, 26, 1'b0});
        sb.push_back('{"ch5", 1, 4, 1'b0});
`else
        sb.push_back('{"ch0", 99, 101, 1'b0});
        sb.push_back('{"ch5", 9, 11, 1'b0});
`endif
        applyStimulus(6'd0, 12'd400, lat, bn);
        e = sb.pop_front();
        checks++; if (int'(count_m) < e.lo || int'(count_m) > e.hi) begin errors++; $display("[TB] FAIL %s_count: got %0d expected %0d..%0d", e.name, count_m, e.lo, e.hi); end
        ackMain();
        applyStimulus(6'd5, 12'd400, lat, bn);
        checks++; if (lat !== 404) begin errors++; $display("[TB] FAIL ch5_latency: got %0d expected 404", lat); end
        e = sb.pop_front();
        checks++; if (int'(count_m) < e.lo || int'(count_m) > e.hi) begin errors++; $display("[TB] FAIL %s_count: got %0d expected %0d..%0d", e.name, count_m, e.lo, e.hi); end
        ackMain();
    endtask

    task automatic test_reset_mid_gate();
        int lat, bn;
        exp_t e;
        @(negedge CLK);
        sel = 6'd0; gate_m = 12'd400; start_m = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_m = 1'b0;
        repeat (100) @(negedge CLK);
        rst_n = 1'b0;
        #1;
        checks++; if (busy_m !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy_m); end
        checks++; if (valid_m !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", valid_m); end
        checks++; if (count_m !== 16'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", count_m); end
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
`ifdef RING_PRESCALE_EN
        sb.push_back('{"postreset", 0, 3, 1'b0});
`else
        sb.push_back('{"postreset", 6, 9, 1'b0});
`endif
        applyStimulus(6'd0, 12'd30, lat, bn);
        checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL postreset_latency: got %0d expected 34", lat); end
        e = sb.pop_front();
        checks++; if (int'(count_m) < e.lo || int'(count_m) > e.hi) begin errors++; $display("[TB] FAIL %s_count: got %0d expected %0d..%0d", e.name, count_m, e.lo, e.hi); end
        ackMain();
    endtask

    initial begin
        sel = 6'd0;
        gate_m = 12'd0; start_m = 1'b0; ack_m = 1'b0;
        start_o = 1'b0; ack_o = 1'b0;
        gate_g = 4'd0; start_g = 1'b0; ack_g = 1'b0;
        test_reset();
        test_basic_count();
        test_handshake();
        test_overflow();
        test_gate_zero();
        test_invalid_sel();
        test_channel_switch();
        test_reset_mid_gate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
